// File: rtl/phase_ctrl_pkg.sv
// Shared types for the phase unwrapper window controller: FSM state
// encoding and small state-decode helpers used by the top level.
package phase_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_ACQUIRE = 3'd3,
        ST_CAPTURE = 3'd4
    } state_t;

    // The unwrapper accumulator is held cleared while parked and during the clear cycle.
    function automatic logic state_clears_acc(input state_t s);
        return (s == ST_IDLE) || (s == ST_CLEAR);
    endfunction

    // Any state other than IDLE means a window is in flight.
    function automatic logic state_is_busy(input state_t s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/phase_unwrapper_ctrl_result_holder.sv
// Result holder: single-entry valid/ready output register. A new capture
// always overwrites the held word; capturing over an unconsumed word sets
// a sticky overrun flag that is only cleared by the controller on re-arm.
module phase_unwrapper_ctrl_result_holder #(
    parameter int DOUT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_capture,
    input  logic [DOUT_WIDTH-1:0] i_data,
    input  logic                  i_ready,
    input  logic                  i_clr_ovr,
    output logic [DOUT_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_overrun
);

    logic [DOUT_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_overrun;
    logic                  w_lost;

    // A held word is lost when a capture lands while it is valid and not being taken.
    always_comb begin
        w_lost = 1'b0;
        if (i_capture && r_valid && !i_ready) begin
            w_lost = 1'b1;
        end else begin
            w_lost = 1'b0;
        end
    end

    // Data/valid register: capture wins over a handshake in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= {DOUT_WIDTH{1'b0}};
            r_valid <= 1'b0;
        end else if (i_capture) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Sticky overrun flag, cleared only when a new measurement is armed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (i_clr_ovr) begin
            r_overrun <= 1'b0;
        end else if (w_lost) begin
            r_overrun <= 1'b1;
        end else begin
            r_overrun <= r_overrun;
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/phase_unwrapper_ctrl.sv
// Phase unwrapper window controller. Clears the unwrapper accumulator,
// waits for its pipeline to settle, enables accumulation for exactly N
// samples and then captures the accumulated phase into a valid/ready
// result register. Supports single-shot and auto re-arming windows.
module phase_unwrapper_ctrl
    import phase_ctrl_pkg::*;
#(
    parameter int DOUT_WIDTH    = 32,
    parameter int CNT_WIDTH     = 24,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  continuous,
    input  logic [CNT_WIDTH-1:0]  n_samples,
    input  logic [DOUT_WIDTH-1:0] phase_acc,
    output logic                  unwrap_rst,
    output logic                  unwrap_acc_on,
    output logic [DOUT_WIDTH-1:0] result_data,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  busy,
    output logic                  overrun,
    output logic [CNT_WIDTH-1:0]  sample_count
);

    // Settle counter only needs to reach SETTLE_CYCLES-1.
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    // A zero-length request is treated as a one-sample window.
    function automatic logic [CNT_WIDTH-1:0] window_len(input logic [CNT_WIDTH-1:0] n);
        return (n == {CNT_WIDTH{1'b0}}) ? CNT_WIDTH'(1) : n;
    endfunction

    state_t               r_state;
    logic [SET_W-1:0]     r_settle;
    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] r_len;
    logic                 r_unwrap_rst;
    logic                 r_acc_on;
    logic                 r_busy;

    state_t               w_state_nxt;
    logic [SET_W-1:0]     w_settle_nxt;
    logic [CNT_WIDTH-1:0] w_count_nxt;
    logic [CNT_WIDTH-1:0] w_len_nxt;
    logic                 w_capture;
    logic                 w_ovr_clr;

    // Next-state, counter and capture decode; stop overrides any transition.
    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle;
        w_count_nxt  = r_count;
        w_len_nxt    = r_len;
        w_capture    = 1'b0;
        w_ovr_clr    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = ST_CLEAR;
                    w_len_nxt   = window_len(n_samples);
                    w_ovr_clr   = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                w_count_nxt  = {CNT_WIDTH{1'b0}};
                w_settle_nxt = {SET_W{1'b0}};
                w_state_nxt  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (r_settle == SETTLE_LAST) begin
                    w_state_nxt = ST_ACQUIRE;
                end else begin
                    w_settle_nxt = r_settle + SET_W'(1);
                end
            end
            ST_ACQUIRE: begin
                // The sample taken this cycle counts even if the window is aborted.
                w_count_nxt = r_count + CNT_WIDTH'(1);
                if (r_count == (r_len - CNT_WIDTH'(1))) begin
                    w_state_nxt = ST_CAPTURE;
                end else begin
                    w_state_nxt = ST_ACQUIRE;
                end
            end
            ST_CAPTURE: begin
                // The unwrapper registers the last enabled sample, so phase_acc is final here.
                w_capture = 1'b1;
                if (continuous) begin
                    w_state_nxt = ST_CLEAR;
                    w_len_nxt   = window_len(n_samples);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (stop && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_capture   = 1'b0;
            w_len_nxt   = r_len;
        end else begin
            w_capture = w_capture;
        end
    end

    // State and window bookkeeping registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_settle <= {SET_W{1'b0}};
            r_count  <= {CNT_WIDTH{1'b0}};
            r_len    <= {CNT_WIDTH{1'b0}};
        end else begin
            r_state  <= w_state_nxt;
            r_settle <= w_settle_nxt;
            r_count  <= w_count_nxt;
            r_len    <= w_len_nxt;
        end
    end

    // Control outputs registered from the next state so they align with the state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_unwrap_rst <= 1'b1;
            r_acc_on     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_unwrap_rst <= state_clears_acc(w_state_nxt);
            r_acc_on     <= (w_state_nxt == ST_ACQUIRE);
            r_busy       <= state_is_busy(w_state_nxt);
        end
    end

    phase_unwrapper_ctrl_result_holder #(
        .DOUT_WIDTH (DOUT_WIDTH)
    ) u_result_holder (
        .clk       (clk),
        .rst_n     (resetn),
        .i_capture (w_capture),
        .i_data    (phase_acc),
        .i_ready   (result_ready),
        .i_clr_ovr (w_ovr_clr),
        .o_data    (result_data),
        .o_valid   (result_valid),
        .o_overrun (overrun)
    );

    assign unwrap_rst    = r_unwrap_rst;
    assign unwrap_acc_on = r_acc_on;
    assign busy          = r_busy;
    assign sample_count  = r_count;

endmodule

// File: doc/phase_unwrapper_ctrl.md
Name: phase_unwrapper_ctrl

Overview:
Sequences a phase unwrapper/accumulator datapath for windowed phase measurement. On a start command it clears the accumulator, waits for the unwrapper pipeline to settle, and enables accumulation for exactly N samples. It then captures the accumulated phase into a result register and presents it on a valid/ready interface. Sits between the PS-side config/status registers and the unwrapper; supports single-shot and continuous windows.

Parameters:
- DOUT_WIDTH, 32, width of accumulated phase from unwrapper and of result_data
- CNT_WIDTH, 24, width of window length and sample counter
- SETTLE_CYCLES, 3, cycles after accumulator clear before acc enable (unwrapper pipeline depth); must be >= 1

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; arms a measurement
- stop  in  1  single-cycle pulse; aborts a measurement
- continuous  in  1  1 = re-arm automatically after each capture
- n_samples  in  CNT_WIDTH  window length in samples, latched on accepted start and on each re-arm
- phase_acc  in  DOUT_WIDTH  signed accumulated phase from unwrapper
- unwrap_rst  out  1  accumulator clear to unwrapper
- unwrap_acc_on  out  1  accumulate enable to unwrapper
- result_data  out  DOUT_WIDTH  signed captured phase
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- busy  out  1  high in any state except IDLE
- overrun  out  1  sticky: a capture occurred while result_valid was still high
- sample_count  out  CNT_WIDTH  samples accumulated so far in current window

Behaviour:
- Reset (resetn low, async): state IDLE; unwrap_rst=1, unwrap_acc_on=0, result_data=0, result_valid=0, busy=0, overrun=0, sample_count=0, latched length=0.
- All outputs registered; state changes on rising clk.
- States: IDLE, CLEAR, SETTLE, ACQUIRE, CAPTURE.
- IDLE: unwrap_rst=1, acc_on=0. start -> CLEAR; latch n_samples (0 latched as 1); clear overrun.
- CLEAR: one cycle, unwrap_rst=1; sample_count<=0 -> SETTLE.
- SETTLE: unwrap_rst=0, acc_on=0 for SETTLE_CYCLES cycles -> ACQUIRE.
- ACQUIRE: acc_on=1 for exactly latched-length cycles; sample_count increments each cycle; on reaching length -> CAPTURE.
- CAPTURE: acc_on=0; phase_acc now holds final sum (unwrapper adds one cycle after enable); result_data<=phase_acc, result_valid<=1. If result_valid already 1 and not handshaken this cycle: overrun<=1, data overwritten. Then continuous=1 -> CLEAR (relatch n_samples), else IDLE.
- Start-to-result_valid latency: 1 (CLEAR) + SETTLE_CYCLES + N + 1 (CAPTURE) cycles after the start cycle.
- Handshake: result_valid cleared in the cycle after result_valid&&result_ready; holds data stable while valid and not ready. Capture and handshake in the same cycle: new result valid, no overrun.
- stop in any non-IDLE state: -> IDLE next cycle, acc_on=0, no capture; existing result_valid/result_data unaffected. stop and start in the same cycle: stop wins, remain/return IDLE.
- start while busy: ignored. n_samples changes mid-window: ignored until next latch.
- Counter width: n_samples up to 2^CNT_WIDTH-1; counter must not wrap within a window.
- Arithmetic: no arithmetic on phase data; result width = DOUT_WIDTH, sign preserved.

Decomposition:
- Package phase_ctrl_pkg: state enum (IDLE, CLEAR, SETTLE, ACQUIRE, CAPTURE), state width constant.
- One sub-module natural: result_holder (single-entry valid/ready register with overrun detection).

Test Plan:
- Single shot: SETTLE_CYCLES=3, n_samples=10, phase_acc driven by model unwrapper with constant step +100 -> acc_on high exactly 10 cycles, result_data=1000, result_valid 15 cycles after start, busy low afterwards.
- n_samples=0 -> treated as 1: acc_on high 1 cycle, result_data=100.
- Continuous, n_samples=4, result_ready held low -> 2nd capture sets overrun=1, result_data=400 (fresh window after clear); next start clears overrun.
- stop asserted on 3rd ACQUIRE cycle -> IDLE next cycle, acc_on=0, unwrap_rst=1, result_valid stays 0.
- start and stop in same cycle from IDLE -> busy stays 0; start during ACQUIRE -> no effect on sample_count.
- resetn asserted mid-ACQUIRE -> outputs immediately (no clock) reset values; unwrap_rst=1, result_valid=0.
